// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first, start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` port for ripple-borrow subtraction.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] rb_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  logic             sbit_next;
  logic             carry_next;
  logic             cout_next;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] ra_shr;
  logic [WIDTH-1:0] rb_shr;
  logic [WIDTH-1:0] b_lat;
  logic             cin_lat;

  // Logical right shift of the operand registers, one lane per bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shr
      assign ra_shr[gi] = ra_reg[gi+1];
      assign rb_shr[gi] = rb_reg[gi+1];
    end
  endgenerate
  assign ra_shr[WIDTH-1] = 1'b0;
  assign rb_shr[WIDTH-1] = 1'b0;

  // The shared full-adder cell.
  assign sbit_next  = ra_reg[0] ^ rb_reg[0] ^ carry_reg;
  assign carry_next = (ra_reg[0] & rb_reg[0]) | (carry_reg & (ra_reg[0] ^ rb_reg[0]));
  assign res_next   = {sbit_next, res_reg[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_reg;

  // Subtraction is a + ~b + ~cin; the borrow-out is the inverted final carry.
  assign b_lat     = sub ? ~b : b;
  assign cin_lat   = sub ? ~cin : cin;
  assign cout_next = carry_next ^ sub_reg;
`else
  assign b_lat     = b;
  assign cin_lat   = cin;
  assign cout_next = carry_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ra_reg    <= '0;
      rb_reg    <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            ra_reg    <= a;
            rb_reg    <= b_lat;
            carry_reg <= cin_lat;
            res_reg   <= '0;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
            sub_reg   <= sub;
`endif
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          ra_reg    <= ra_shr;
          rb_reg    <= rb_shr;
          carry_reg <= carry_next;
          res_reg   <= res_next;
          count_reg <= count_reg + 1'b1;
          // s/cout publish only here so partial sums never reach the outputs.
          if (count_reg == LAST_STEP) begin
            s_reg     <= res_next;
            cout_reg  <= cout_next;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign s    = s_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): directed cases plus random operands vs. an arithmetic model.
// Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_i;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  // {cout,s} from plain integer arithmetic; for subtraction cout is the borrow.
  function automatic logic [W:0] model(input int ua, input int ub, input int uc, input int us);
    int         r;
    logic [W:0] v;
    if (us != 0) begin
      r      = ua - ub - uc;
      v[W]   = (r < 0);
      v[W-1:0] = W'((r + (1 << W)) % (1 << W));
    end else begin
      r = ua + ub + uc;
      v = (W + 1)'(r);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, input string tag);
    logic [W:0]   expv;
    logic [W-1:0] hold_s;
    logic         hold_c;
    int           edges;
    expv   = model(int'(ta), int'(tb_v), int'(tcin), int'(tsub));
    hold_s = s;
    hold_c = cout;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub_i = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk({tag, ".busy_after_start"}, 32'(busy), 32'd1);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      chk({tag, ".hold_while_busy"}, 32'({cout, s}), 32'({hold_c, hold_s}));
      chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
      @(negedge clk);
      edges++;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(W));
    chk({tag, ".s"}, 32'(s), 32'(expv[W-1:0]));
    chk({tag, ".cout"}, 32'(cout), 32'(expv[W]));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, ".done_fall"}, 32'(done), 32'd0);
    chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
    $display("op %s a=%0d b=%0d cin=%0d sub=%0d -> s=%0d cout=%0d (latency %0d)",
             tag, ta, tb_v, tcin, tsub, s, cout, edges);
  endtask

  initial begin
    int edges;
    int dones;
    logic tsub;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;

    // 1. reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.s", 32'(s), 32'd0);
    chk("reset.cout", 32'(cout), 32'd0);

    // 2. basic add
    run_op(4'd3, 4'd5, 1'b0, 1'b0, "add3_5");

    // 3. carry-out plus hold
    run_op(4'd15, 4'd1, 1'b1, 1'b0, "add15_1_1");
    repeat (10) @(negedge clk);
    chk("hold10.s", 32'(s), 32'd1);
    chk("hold10.cout", 32'(cout), 32'd1);
    chk("hold10.done", 32'(done), 32'd0);

    // 4. start while busy is ignored
    @(negedge clk);
    a = 4'd2; b = 4'd2; cin = 1'b0; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        dones++;
        chk("ignore.s", 32'(s), 32'd4);
      end
      @(negedge clk);
    end
    chk("ignore.done_count", 32'(dones), 32'd1);
    chk("ignore.busy_idle", 32'(busy), 32'd0);
    $display("op ignore_start a=2 b=2 (second start a=1 b=1) -> s=%0d dones=%0d", s, dones);

    // 5. reset mid-operation
    @(negedge clk);
    a = 4'd7; b = 4'd7; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.s", 32'(s), 32'd0);
    chk("midrst.cout", 32'(cout), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("midrst.no_done", 32'(dones), 32'd0);
    $display("op mid_reset a=7 b=7 -> s=%0d cout=%0d busy=%0d", s, cout, busy);
    run_op(4'd7, 4'd7, 1'b0, 1'b0, "add7_7_after_rst");

`ifdef SERIAL_ADDER_SUB_EN
    // 6. subtraction
    run_op(4'd3, 4'd5, 1'b0, 1'b1, "sub3_5");
    run_op(4'd9, 4'd4, 1'b1, 1'b1, "sub9_4_1");
`endif

    // Random operands, including back-to-back restarts from IDLE
    for (int i = 0; i < 24; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
      tsub = 1'($urandom_range(0, 1));
`else
      tsub = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), tsub, "rand");
    end

    // Edge cases: all-zero and all-ones
    run_op(4'd0, 4'd0, 1'b0, 1'b0, "zero");
    run_op(4'd15, 4'd15, 1'b1, 1'b0, "ones");

    edges = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
